// File: rtl/bcd_convert_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Optional overflow flag enabled by defining BCD_OVF_EN.
module bcd_convert_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  shift_q;
  logic [BcdW-1:0]   digits_q;
  logic [BcdW-1:0]   digits_adj;
  logic [BcdW-1:0]   bcd_q;
  logic [CntW-1:0]   count_q;
  logic              done_q;
  logic              last_bit;

  // Add-3 correction per digit; 4-bit wrap, no carry between digits.
  always_comb begin
    digits_adj = digits_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digits_q[4*i +: 4] >= 4'd5) begin
        digits_adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign last_bit = (count_q == CntW'(BIN_W - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start)    state_d = StConv;
      StConv: if (last_bit) state_d = StDone;
      StDone:               state_d = StIdle;
      default:              state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q  <= '0;
      digits_q <= '0;
      count_q  <= '0;
      bcd_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == StDone);
      unique case (state_q)
        StIdle: begin
          if (start) begin
            shift_q  <= bin;
            digits_q <= '0;
            count_q  <= '0;
          end
        end
        StConv: begin
          digits_q <= {digits_adj[BcdW-2:0], shift_q[BIN_W-1]};
          shift_q  <= shift_q << 1;
          count_q  <= count_q + CntW'(1);
        end
        StDone:  bcd_q <= digits_q;
        default: ;
      endcase
    end
  end

`ifdef BCD_OVF_EN
  logic flag_q;
  logic ovf_q;

  // Sticky: any 1 leaving the top digit means the value was truncated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  if (start) flag_q <= 1'b0;
        StConv:  if (digits_adj[BcdW-1]) flag_q <= 1'b1;
        StDone:  ovf_q <= flag_q;
        default: ;
      endcase
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Scoreboard bench for bcd_convert_seq: stimulus pushes expected results, a monitor
// pops them on each done pulse. Under BCD_OVF_EN, runs with DIGITS=2 and checks ovf.
module tb_bcd_convert_seq;

  localparam int unsigned BIN_W = 8;
`ifdef BCD_OVF_EN
  localparam int unsigned DIGITS = 2;
`else
  localparam int unsigned DIGITS = 3;
`endif
  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int Lat = BIN_W + 1;

  typedef struct {
    logic [BcdW-1:0] bcd;
    logic            ovf;
    int              cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [BIN_W-1:0]  bin = '0;
  logic              busy;
  logic              done;
  logic [BcdW-1:0]   bcd;
  logic              ovf_obs;

  int   cyc = 0;
  int   last_acc = -100;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  bcd_convert_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
`ifdef BCD_OVF_EN
    ,
    .ovf   (ovf_obs)
`endif
  );

`ifndef BCD_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Decimal digits of v, truncated to DIGITS places.
  function automatic logic [BcdW-1:0] ref_bcd(input int v);
    logic [BcdW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int v);
`ifdef BCD_OVF_EN
    return v >= 10 ** DIGITS;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk_exp(input int v, input int acc);
    exp_t e;
    e.bcd = ref_bcd(v);
    e.ovf = ref_ovf(v);
    e.cyc = acc + Lat;
    return e;
  endfunction

  // Monitor: pops on every done pulse, and tracks expected busy window.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("done_cycle", 32'(cyc), 32'(e.cyc));
`ifdef BCD_OVF_EN
        check("ovf", 32'(ovf_obs), 32'(e.ovf));
`endif
      end
    end
    exp_busy = (cyc >= last_acc) && (cyc < last_acc + Lat);
    check("busy", 32'(busy), 32'(exp_busy));
  end

  // Issue one conversion at the earliest idle cycle.
  task automatic send(input int v);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      check("idle_timeout", 32'(busy), 32'd0);
    end else begin
      bin = BIN_W'(v);
      start = 1'b1;
      last_acc = cyc + 1;
      sb.push_back(mk_exp(v, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      bin = BIN_W'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int acc;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_ovf", 32'(ovf_obs), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed values, each idle-gapped.
    send(255); drain();
    send(0);   drain();
    send(9);   drain();
    send(10);  drain();
    send(99);  drain();
    send(200); drain();

    // Start held high; bin changes mid-flight; second accept at E+BIN_W+2.
    bin = 8'd128;
    start = 1'b1;
    acc = cyc + 1;
    last_acc = acc;
    sb.push_back(mk_exp(128, acc));
    repeat (3) @(negedge clk);
    bin = 8'd1;
    sb.push_back(mk_exp(1, acc + Lat + 1));
    while (cyc < acc + Lat) @(negedge clk);
    last_acc = acc + Lat + 1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset during conversion aborts it.
    send(200);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    sb.delete();
    last_acc = -100;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'd0);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done_bcd", 32'(bcd), 32'd0);
    send(42); drain();

    // All inputs back to back, then random with random gaps.
    for (int v = 0; v < (1 << BIN_W); v++) send(v);
    drain();
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(int'($urandom_range(0, (1 << BIN_W) - 1)));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
